// File: rtl/decoder_scan_ctrl.sv
// Scan controller for a 2x4 decoder: steps a 2-bit select through the enabled digits,
// holding en high for PRESCALE cycles per digit with BLANK_CYC cycles of blanking between.
module decoder_scan_ctrl #(
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [3:0] digit_mask_i,
  output logic [1:0] sel_o,
  output logic       en_o,
  output logic       frame_done_o,
  output logic       busy_o
);

  localparam int DW = (PRESCALE  > 1) ? $clog2(PRESCALE + 1)  : 1;
  localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    BLANK
  } state_e;

  state_e        state_q;
  logic [DW-1:0] dwell_q;
  logic [BW-1:0] blank_q;
  logic [1:0]    sel_q;
  logic          en_q;
  logic          frame_done_q;
  logic          busy_q;

  logic [1:0]    first_sel_d;
  logic [1:0]    adv_sel_d;
  logic [1:0]    cand;
  logic          adv_ok_d;
  logic          adv_wrap_d;
  logic          advance;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    first_sel_d = 2'd0;
    adv_sel_d   = sel_q;
    adv_ok_d    = 1'b0;
    cand        = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (digit_mask_i[i]) first_sel_d = 2'(i);
    end
    // Walk offsets 4..1 so the nearest following set bit is written last and wins.
    for (int i = 4; i >= 1; i--) begin
      cand = sel_q + 2'(i);
      if (digit_mask_i[cand]) begin
        adv_sel_d = cand;
        adv_ok_d  = 1'b1;
      end
    end
    adv_wrap_d = (adv_sel_d <= sel_q);
    advance    = !stop_i &&
                 (((state_q == DWELL) && (dwell_q == DWELL_LAST) && (BLANK_CYC == 0)) ||
                  ((state_q == BLANK) && (blank_q == BLANK_LAST)));
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register sees pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dwell_q      <= '0;
      blank_q      <= '0;
      sel_q        <= 2'd0;
      en_q         <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (advance) begin
        dwell_q <= '0;
        blank_q <= '0;
        if (adv_ok_d) begin
          state_q      <= DWELL;
          sel_q        <= adv_sel_d;
          en_q         <= 1'b1;
          busy_q       <= 1'b1;
          frame_done_q <= adv_wrap_d;
        end else begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i && !stop_i && (digit_mask_i != 4'd0)) begin
              state_q <= DWELL;
              sel_q   <= first_sel_d;
              en_q    <= 1'b1;
              busy_q  <= 1'b1;
              dwell_q <= '0;
            end
          end
          DWELL: begin
            if (stop_i) begin
              state_q <= IDLE;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              dwell_q <= '0;
            end else if (dwell_q == DWELL_LAST) begin
              state_q <= BLANK;
              en_q    <= 1'b0;
              dwell_q <= '0;
              blank_q <= '0;
            end else begin
              dwell_q <= dwell_q + DW'(1);
            end
          end
          BLANK: begin
            if (stop_i) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              blank_q <= '0;
            end else begin
              blank_q <= blank_q + BW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel_o        = sel_q;
  assign en_o         = en_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;

endmodule
